// File: rtl/btb_pkg.sv
// Shared types and helpers for the N-way branch target buffer.
// Holds the 2-bit direction counter encodings, the per-entry metadata
// struct and the index/tag width helpers used by btb_nway.
package btb_pkg;

    // 2-bit direction counter encodings; bit 1 is the predicted direction.
    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Per-entry metadata. The tag and target live in their own arrays
    // because their widths depend on the XLEN/SETS parameters.
    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } btb_entry_t;

    // Number of PC bits used to select a set.
    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    // Number of PC bits kept as the tag (above the index and byte offset).
    function automatic int tag_bits(input int xlen, input int sets);
        return xlen - $clog2(sets) - 2;
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// Next-state logic for a 2-bit saturating up/down direction counter.
// Counts up when the branch resolved taken, down otherwise, and sticks
// at STRONG_T / STRONG_NT.
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       up_i,
    output logic [1:0] ctr_o
);

    // Saturating increment/decrement.
    always_comb begin
        ctr_o = ctr_i;
        if (up_i && (ctr_i != STRONG_T)) begin
            ctr_o = ctr_i + 2'd1;
        end else if (!up_i && (ctr_i != STRONG_NT)) begin
            ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/btb_nway.sv
// N-way set-associative branch target buffer.
// Stage-1 PC is looked up combinationally; the stage-3 resolved branch
// trains the table at the clock edge and raises flush on a direction
// mispredict. Victims are the lowest invalid way, else the per-set
// round-robin pointer. Optional statistics counters are built when the
// BTB_STATS_EN macro is defined.
module btb_nway
    import btb_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 16,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            memory_stall,
    input  logic [XLEN-1:0] instructionPC_1,
    output logic            taken,
    output logic [XLEN-1:0] branchPC,
    output logic            flush,
    input  logic [XLEN-1:0] instructionPC_3,
    input  logic            is_branchInst_3,
    input  logic            taken_3,
    input  logic            prev_taken_3,
    input  logic [XLEN-1:0] target_3
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]     btb_lookups,
    output logic [31:0]     btb_hits,
    output logic [31:0]     btb_mispredicts
`endif
);

    localparam int IW = idx_bits(SETS);
    localparam int TW = tag_bits(XLEN, SETS);
    localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

    btb_entry_t      meta_q   [SETS][WAYS];
    logic [TW-1:0]   tag_q    [SETS][WAYS];
    logic [XLEN-1:0] target_q [SETS][WAYS];
    logic [PW-1:0]   ptr_q    [SETS];

    // Byte-offset bits never take part in lookup or training.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{instructionPC_1[1:0], instructionPC_3[1:0]};

    logic [IW-1:0] idx1, idx3;
    logic [TW-1:0] tag1, tag3;
    assign idx1 = instructionPC_1[IW+1:2];
    assign tag1 = instructionPC_1[XLEN-1:IW+2];
    assign idx3 = instructionPC_3[IW+1:2];
    assign tag3 = instructionPC_3[XLEN-1:IW+2];

    logic            hit1;
    logic [1:0]      ctr1;
    logic [XLEN-1:0] tgt1;

    // Stage-1 lookup against the current (pre-update) table contents.
    always_comb begin
        hit1 = 1'b0;
        ctr1 = WEAK_NT;
        tgt1 = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (meta_q[idx1][w].valid && (tag_q[idx1][w] == tag1)) begin
                hit1 = 1'b1;
                ctr1 = meta_q[idx1][w].ctr;
                tgt1 = target_q[idx1][w];
            end
        end
    end

    assign taken = hit1 & ctr1[1];
    assign flush = is_branchInst_3 & (taken_3 != prev_taken_3);

    // Redirect PC: recovery path on flush wins over the prediction.
    always_comb begin
        branchPC = '0;
        if (flush) begin
            branchPC = taken_3 ? target_3 : (instructionPC_3 + XLEN'(4));
        end else if (taken) begin
            branchPC = tgt1;
        end
    end

    logic          hit3;
    logic [PW-1:0] hit_way3;
    logic [1:0]    ctr3;
    logic          inv_found;
    logic [PW-1:0] inv_way;
    logic [PW-1:0] victim;
    logic [PW-1:0] ptr_d;
    logic [1:0]    ctr3_d;
    logic          train_en;

    // Stage-3 probe: hit way, its counter, and the lowest invalid way.
    always_comb begin
        hit3      = 1'b0;
        hit_way3  = '0;
        ctr3      = WEAK_NT;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (meta_q[idx3][w].valid && (tag_q[idx3][w] == tag3)) begin
                hit3     = 1'b1;
                hit_way3 = PW'(w);
                ctr3     = meta_q[idx3][w].ctr;
            end
            if (!meta_q[idx3][w].valid && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = PW'(w);
            end
        end
    end

    // Victim choice and the pointer value after an allocation.
    always_comb begin
        victim = inv_found ? inv_way : ptr_q[idx3];
        ptr_d  = (ptr_q[idx3] == PW'(WAYS - 1)) ? '0 : ptr_q[idx3] + 1'b1;
    end

    assign train_en = is_branchInst_3 & ~memory_stall;

    btb_sat_ctr u_ctr (
        .ctr_i (ctr3),
        .up_i  (taken_3),
        .ctr_o (ctr3_d)
    );

    // Table state: reset clear, then train on unstalled stage-3 branches.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    meta_q[s][w]   <= '{valid: 1'b0, ctr: WEAK_NT};
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                end
            end
        end else if (train_en) begin
            if (hit3) begin
                meta_q[idx3][hit_way3].ctr <= ctr3_d;
                if (taken_3) begin
                    target_q[idx3][hit_way3] <= target_3;
                end
            end else if (taken_3) begin
                meta_q[idx3][victim]   <= '{valid: 1'b1, ctr: WEAK_T};
                tag_q[idx3][victim]    <= tag3;
                target_q[idx3][victim] <= target_3;
                ptr_q[idx3]            <= ptr_d;
            end
        end
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_q, hits_q, mispredicts_q;

    // Saturating event counters, frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q     <= '0;
            hits_q        <= '0;
            mispredicts_q <= '0;
        end else if (!memory_stall) begin
            if (lookups_q != '1) lookups_q <= lookups_q + 32'd1;
            if (hit1 && (hits_q != '1)) hits_q <= hits_q + 32'd1;
            if (flush && (mispredicts_q != '1)) mispredicts_q <= mispredicts_q + 32'd1;
        end
    end

    assign btb_lookups     = lookups_q;
    assign btb_hits        = hits_q;
    assign btb_mispredicts = mispredicts_q;
`endif

endmodule

// File: tb/tb_btb_nway.sv
// Self-checking bench for btb_nway (WAYS=2, SETS=16, XLEN=32).
// Directed walk through the reference scenarios followed by randomized
// traffic, all compared against a behavioural model of the BTB rules.
module tb_btb_nway;

    localparam int W = 2;
    localparam int S = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        memory_stall;
    logic [31:0] instructionPC_1;
    logic        taken;
    logic [31:0] branchPC;
    logic        flush;
    logic [31:0] instructionPC_3;
    logic        is_branchInst_3;
    logic        taken_3;
    logic        prev_taken_3;
    logic [31:0] target_3;
`ifdef BTB_STATS_EN
    logic [31:0] btb_lookups, btb_hits, btb_mispredicts;
`endif

    btb_nway #(.WAYS(W), .SETS(S), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .memory_stall    (memory_stall),
        .instructionPC_1 (instructionPC_1),
        .taken           (taken),
        .branchPC        (branchPC),
        .flush           (flush),
        .instructionPC_3 (instructionPC_3),
        .is_branchInst_3 (is_branchInst_3),
        .taken_3         (taken_3),
        .prev_taken_3    (prev_taken_3),
        .target_3        (target_3)
`ifdef BTB_STATS_EN
        ,
        .btb_lookups     (btb_lookups),
        .btb_hits        (btb_hits),
        .btb_mispredicts (btb_mispredicts)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: per set, a list of ways with plain fields.
    bit          m_valid [S][W];
    int unsigned m_tag   [S][W];
    logic [31:0] m_tgt   [S][W];
    int          m_ctr   [S][W];
    int          m_ptr   [S];
    int unsigned m_lk, m_hit, m_mp;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 0; s < S; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < W; w++) begin
                m_valid[s][w] = 0;
                m_tag[s][w]   = 0;
                m_tgt[s][w]   = 0;
                m_ctr[s][w]   = 1;
            end
        end
        m_lk = 0; m_hit = 0; m_mp = 0;
    endtask

    // Returns the matching way or -1.
    function automatic int m_find(input logic [31:0] pc);
        int set = int'((pc >> 2) % S);
        int unsigned tag = pc >> 6;
        for (int w = 0; w < W; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) return w;
        return -1;
    endfunction

    // One cycle: drive, check combinational outputs mid-cycle, then
    // advance the model at the clock edge.
    task automatic step(input bit do_chk, input logic r, input logic st,
                        input logic [31:0] pc1, input logic br, input logic t3,
                        input logic pt3, input logic [31:0] pc3, input logic [31:0] tg3);
        int set1, way1, set3, way3, vic;
        logic exp_taken, exp_flush;
        logic [31:0] exp_bpc;
        rst = r; memory_stall = st; instructionPC_1 = pc1; is_branchInst_3 = br;
        taken_3 = t3; prev_taken_3 = pt3; instructionPC_3 = pc3; target_3 = tg3;
        @(negedge clk);
        set1 = int'((pc1 >> 2) % S);
        way1 = m_find(pc1);
        exp_taken = (way1 >= 0) && (m_ctr[set1][way1] >= 2);
        exp_flush = br && (t3 != pt3);
        if (exp_flush)      exp_bpc = t3 ? tg3 : pc3 + 32'd4;
        else if (exp_taken) exp_bpc = m_tgt[set1][way1];
        else                exp_bpc = 32'd0;
        if (do_chk) begin
            check("taken", {31'd0, taken}, {31'd0, exp_taken});
            check("flush", {31'd0, flush}, {31'd0, exp_flush});
            check("branchPC", branchPC, exp_bpc);
`ifdef BTB_STATS_EN
            check("lookups", btb_lookups, m_lk);
            check("hits", btb_hits, m_hit);
            check("mispredicts", btb_mispredicts, m_mp);
`endif
        end
        @(posedge clk);
        if (r) begin
            m_reset();
        end else if (!st) begin
            m_lk++;
            if (way1 >= 0) m_hit++;
            if (exp_flush) m_mp++;
            if (br) begin
                set3 = int'((pc3 >> 2) % S);
                way3 = m_find(pc3);
                if (way3 >= 0) begin
                    if (t3) begin
                        if (m_ctr[set3][way3] < 3) m_ctr[set3][way3]++;
                        m_tgt[set3][way3] = tg3;
                    end else if (m_ctr[set3][way3] > 0) begin
                        m_ctr[set3][way3]--;
                    end
                end else if (t3) begin
                    vic = -1;
                    for (int w = W - 1; w >= 0; w--) if (!m_valid[set3][w]) vic = w;
                    if (vic < 0) vic = m_ptr[set3];
                    m_valid[set3][vic] = 1;
                    m_tag[set3][vic]   = pc3 >> 6;
                    m_tgt[set3][vic]   = tg3;
                    m_ctr[set3][vic]   = 2;
                    m_ptr[set3]        = (m_ptr[set3] + 1) % W;
                end
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] pa, pb, tg;
        m_reset();
        @(posedge clk); #1;
        // Reset
        step(0, 1, 0, 32'h100, 0, 0, 0, 32'h0, 32'h0);
        // Directed scenarios
        step(1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   32'h0);
        step(1, 0, 0, 32'h100, 1, 1, 0, 32'h100, 32'h200);
        check("hit_after_train", {31'd0, taken}, 32'd1);
        step(1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   32'h0);
        step(1, 0, 0, 32'h100, 1, 0, 1, 32'h100, 32'h0);
        step(1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   32'h0);
        step(1, 0, 0, 32'h0,   1, 1, 0, 32'h500, 32'h600);
        step(1, 0, 0, 32'h0,   1, 1, 0, 32'h900, 32'hA00);
        step(1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   32'h0);
        check("evicted_0x100", {31'd0, taken}, 32'd0);
        step(1, 0, 0, 32'h500, 0, 0, 0, 32'h0,   32'h0);
        step(1, 0, 0, 32'h900, 0, 0, 0, 32'h0,   32'h0);
        step(1, 0, 1, 32'h0,   1, 1, 0, 32'h300, 32'h700);
        step(1, 0, 1, 32'h300, 0, 0, 0, 32'h0,   32'h0);
        step(1, 0, 0, 32'h300, 0, 0, 0, 32'h0,   32'h0);
        check("stalled_no_alloc", {31'd0, taken}, 32'd0);
        // Randomized traffic on a small PC pool so sets conflict often
        for (int i = 0; i < 3000; i++) begin
            pa = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            pb = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            tg = $urandom;
            step(1, ($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 pa, ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 1), pb, tg);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
